booth_controller: RTL and testbench

- Sequencing FSM for the radix-2 Booth multiplier datapath (A accumulator, Q multiplier, Q-1 bit, M multiplicand registers, adder/subtractor, arithmetic shifter).
- Accepts a start request, issues one-hot-in-time load/clear/add/sub/shift strobes per iteration from datapath status bits (q0, q_m1), and counts WIDTH iterations.
- Holds done until acknowledged. Contains no arithmetic; sits between the top-level wrapper and the datapath.

---
 rtl/booth_pkg.sv | 61 ++++++
 rtl/booth_iter_counter.sv | 39 +++
 rtl/booth_controller.sv | 94 +++++++++
 tb/tb_booth_controller.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared encodings for the Booth multiplier sequencer: state codes, Booth pair codes,
// the registered strobe bundle and the helpers that derive it.
package booth_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_EVAL  = 3'd2;
    localparam logic [2:0] ST_ADD   = 3'd3;
    localparam logic [2:0] ST_SUB   = 3'd4;
    localparam logic [2:0] ST_SHIFT = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        EVAL  = ST_EVAL,
        ADD   = ST_ADD,
        SUB   = ST_SUB,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

    // {q0, q_m1} patterns that call for an add or a subtract before the shift
    localparam logic [1:0] PAIR_ADD = 2'b01;
    localparam logic [1:0] PAIR_SUB = 2'b10;

    typedef struct packed {
        logic load_mq;
        logic clr_a;
        logic clr_qm1;
        logic add_en;
        logic sub_en;
        logic shift_en;
        logic busy;
        logic done;
    } ctrl_out_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic ctrl_out_t decode_outputs(input state_t s);
        ctrl_out_t o;
        o      = '0;
        o.busy = (s != IDLE);
        case (s)
            LOAD: begin
                o.load_mq = 1'b1;
                o.clr_a   = 1'b1;
                o.clr_qm1 = 1'b1;
            end
            ADD:     o.add_en   = 1'b1;
            SUB:     o.sub_en   = 1'b1;
            SHIFT:   o.shift_en = 1'b1;
            DONE:    o.done     = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/booth_iter_counter.sv
// Loadable iteration down-counter; last flags the final pass (count == 1).
module booth_iter_counter
    import booth_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = CNT_W'(WIDTH);
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == CNT_W'(1));

endmodule

// File: rtl/booth_controller.sv
// Radix-2 Booth sequencer: walks LOAD, then WIDTH x (EVAL, [ADD|SUB], SHIFT), then holds DONE.
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | load M/Q, clear A and Q-1, arm iteration counter
//   EVAL  | sample {q0,q_m1} to pick add, sub or plain shift
//   ADD   | A <= A + M
//   SUB   | A <= A - M
//   SHIFT | arithmetic shift of {A,Q,Q-1}, one iteration consumed
//   DONE  | product valid, wait for done_ack
module booth_controller
    import booth_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             abort,
    input  logic             q0,
    input  logic             q_m1,
    input  logic             done_ack,
    output logic             load_mq,
    output logic             clr_a,
    output logic             clr_qm1,
    output logic             add_en,
    output logic             sub_en,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter
);

    state_t    state_q;
    state_t    state_d;
    ctrl_out_t out_q;
    ctrl_out_t out_d;
    logic      cnt_last;

    booth_iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk   (clk),
        .clear (clear),
        .load  (state_q == LOAD),
        .dec   (state_q == SHIFT),
        .count (iter),
        .last  (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = LOAD;
            LOAD:  state_d = EVAL;
            EVAL: begin
                case ({q0, q_m1})
                    PAIR_SUB: state_d = SUB;
                    PAIR_ADD: state_d = ADD;
                    default:  state_d = SHIFT;
                endcase
            end
            ADD:   state_d = SHIFT;
            SUB:   state_d = SHIFT;
            SHIFT: state_d = cnt_last ? DONE : EVAL;
            DONE:  if (done_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
        // strobes are registered: decode the state being entered
        out_d = decode_outputs(state_d);
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign load_mq  = out_q.load_mq;
    assign clr_a    = out_q.clr_a;
    assign clr_qm1  = out_q.clr_qm1;
    assign add_en   = out_q.add_en;
    assign sub_en   = out_q.sub_en;
    assign shift_en = out_q.shift_en;
    assign busy     = out_q.busy;
    assign done     = out_q.done;

endmodule

// File: tb/tb_booth_controller.sv
// Bench for booth_controller at WIDTH=4: datapath model feeds q0/q_m1, a schedule model
// built from the multiplier bits predicts every output cycle, plus directed literal pins.
module tb_booth_controller;

    localparam int W = 4;
    localparam int CW = 3;

    localparam logic [7:0] V_IDLE  = 8'b000_000_0_0;
    localparam logic [7:0] V_LOAD  = 8'b111_000_1_0;
    localparam logic [7:0] V_EVAL  = 8'b000_000_1_0;
    localparam logic [7:0] V_ADD   = 8'b000_100_1_0;
    localparam logic [7:0] V_SUB   = 8'b000_010_1_0;
    localparam logic [7:0] V_SHIFT = 8'b000_001_1_0;
    localparam logic [7:0] V_DONE  = 8'b000_000_1_1;

    logic clk, clear, start, abort, done_ack;
    logic q0, q_m1;
    logic load_mq, clr_a, clr_qm1, add_en, sub_en, shift_en, busy, done;
    logic [CW-1:0] iter;

    booth_controller #(.WIDTH(W)) dut (
        .clk(clk), .clear(clear), .start(start), .abort(abort),
        .q0(q0), .q_m1(q_m1), .done_ack(done_ack),
        .load_mq(load_mq), .clr_a(clr_a), .clr_qm1(clr_qm1),
        .add_en(add_en), .sub_en(sub_en), .shift_en(shift_en),
        .busy(busy), .done(done), .iter(iter)
    );

    wire [7:0] outs = {load_mq, clr_a, clr_qm1, add_en, sub_en, shift_en, busy, done};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- datapath model ----------------
    logic [3:0] op_m, op_q;
    logic [3:0] dp_a, dp_q, dp_m;
    logic       dp_qm1;
    logic [7:0] exp_prod;

    assign q0   = dp_q[0];
    assign q_m1 = dp_qm1;

    initial begin
        dp_a = '0; dp_q = '0; dp_m = '0; dp_qm1 = 1'b0; exp_prod = '0;
    end

    always @(posedge clk) begin
        if (load_mq) begin
            dp_m     <= op_m;
            dp_q     <= op_q;
            dp_a     <= '0;
            dp_qm1   <= 1'b0;
            exp_prod <= 8'($signed({{4{op_m[3]}}, op_m}) * $signed({{4{op_q[3]}}, op_q}));
        end else if (add_en) begin
            dp_a <= dp_a + dp_m;
        end else if (sub_en) begin
            dp_a <= dp_a - dp_m;
        end else if (shift_en) begin
            {dp_a, dp_q, dp_qm1} <= {dp_a[3], dp_a, dp_q};
        end
    end

    // ---------------- schedule model ----------------
    logic [7:0]    exp_v;
    logic [CW-1:0] exp_iter;
    logic [7:0]    sched[$];
    logic          prev;
    logic [1:0]    pair;
    int            rel;
    bit            tracking;

    initial begin
        exp_v = V_IDLE;
        exp_iter = '0;
        rel = 0;
        tracking = 0;
        forever begin
            @(posedge clk or posedge clear);
            if (clear) begin
                exp_v = V_IDLE;
                exp_iter = '0;
                sched.delete();
            end else begin
                if (tracking) rel++;
                if (exp_v == V_LOAD) exp_iter = CW'(W);
                else if (exp_v == V_SHIFT && exp_iter != 0) exp_iter = exp_iter - 1'b1;
                if (abort) begin
                    sched.delete();
                    exp_v = V_IDLE;
                end else if (exp_v == V_IDLE) begin
                    if (start) begin
                        sched.delete();
                        sched.push_back(V_LOAD);
                        prev = 1'b0;
                        for (int i = 0; i < W; i++) begin
                            pair = {op_q[i], prev};
                            sched.push_back(V_EVAL);
                            if (pair == 2'b10) sched.push_back(V_SUB);
                            else if (pair == 2'b01) sched.push_back(V_ADD);
                            sched.push_back(V_SHIFT);
                            prev = op_q[i];
                        end
                        exp_v = sched.pop_front();
                    end
                end else if (exp_v == V_DONE) begin
                    if (done_ack) exp_v = V_IDLE;
                end else begin
                    exp_v = (sched.size() != 0) ? sched.pop_front() : V_DONE;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    logic [63:0] load_mask, sub_mask, add_mask, shift_mask, done_mask;
    int          done_first;
    logic        done_prev;

    initial begin
        done_prev = 1'b0;
        load_mask = '0; sub_mask = '0; add_mask = '0; shift_mask = '0; done_mask = '0;
        done_first = -1;
        forever begin
            @(negedge clk);
            if (!clear) begin
                chk("outputs", {53'd0, outs, iter}, {53'd0, exp_v, exp_iter});
                if (done && !done_prev) chk("product", {dp_a, dp_q}, exp_prod);
                if (tracking && rel > 0 && rel < 64) begin
                    if (load_mq)  load_mask[rel]  = 1'b1;
                    if (sub_en)   sub_mask[rel]   = 1'b1;
                    if (add_en)   add_mask[rel]   = 1'b1;
                    if (shift_en) shift_mask[rel] = 1'b1;
                    if (done)     done_mask[rel]  = 1'b1;
                    if (done && done_first < 0) done_first = rel;
                end
            end
            done_prev = done;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic begin_op(input logic [3:0] m, input logic [3:0] qv, input bit hold);
        @(negedge clk);
        op_m = m;
        op_q = qv;
        rel = 0;
        tracking = 1;
        load_mask = '0; sub_mask = '0; add_mask = '0; shift_mask = '0; done_mask = '0;
        done_first = -1;
        start = 1'b1;
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", {63'd0, done}, 64'd1);
        @(negedge clk);
    endtask

    task automatic ack();
        done_ack = 1'b1;
        @(negedge clk);
        done_ack = 1'b0;
    endtask

    initial begin
        int n;
        clear = 1'b1; start = 1'b0; abort = 1'b0; done_ack = 1'b0;
        op_m = 4'd0; op_q = 4'd0;
        repeat (3) @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        chk("reset_state", {53'd0, outs, iter}, 64'd0);

        // 3 * 6: pairs 00,10,11,01
        begin_op(4'd3, 4'b0110, 0);
        wait_done();
        chk("a_load_cycle", load_mask, 64'h2);
        chk("a_sub_cycle", sub_mask, 64'h20);
        chk("a_add_cycle", add_mask, 64'h400);
        chk("a_shift_cycles", shift_mask, 64'h948);
        chk("a_done_cycle", done_first, 12);
        chk("a_product", {dp_a, dp_q}, 8'd18);
        chk("a_iter_end", iter, 0);
        ack();

        // minimum latency
        begin_op(4'd7, 4'b0000, 0);
        wait_done();
        chk("b_done_cycle", done_first, 10);
        chk("b_no_addsub", add_mask | sub_mask, 64'd0);
        chk("b_product", {dp_a, dp_q}, 8'd0);
        ack();

        // maximum latency: Q=0101 gives pairs 10,01,10,01; -5 * 5 = -25
        begin_op(4'b1011, 4'b0101, 0);
        wait_done();
        chk("c_done_cycle", done_first, 14);
        chk("c_addsub_count", $countones(add_mask | sub_mask), 4);
        chk("c_shift_count", $countones(shift_mask), 4);
        chk("c_product", {dp_a, dp_q}, 8'hE7);
        ack();

        // abort at cycle 7 with start held throughout the run
        begin_op(4'd3, 4'b0110, 1);
        while (rel < 7) @(negedge clk);
        abort = 1'b1;
        start = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        chk("d_busy_after_abort", {63'd0, busy}, 64'd0);
        repeat (20) @(negedge clk);
        chk("d_no_done", done_mask, 64'd0);

        // delayed ack, then start together with done_ack
        begin_op(4'd2, 4'b0101, 0);
        wait_done();
        repeat (5) @(negedge clk);
        chk("e_done_held", {56'd0, outs}, {56'd0, V_DONE});
        start = 1'b1;
        done_ack = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_ack = 1'b0;
        chk("e_idle_after_ack", {63'd0, busy}, 64'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("e_new_load", {63'd0, load_mq}, 64'd1);
        wait_done();
        ack();

        // async clear while in SUB
        begin_op(4'd3, 4'b0110, 0);
        n = 0;
        while (!sub_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("f_reached_sub", {63'd0, sub_en}, 64'd1);
        #1 clear = 1'b1;
        #1 chk("f_clear_immediate", {53'd0, outs, iter}, 64'd0);
        repeat (2) @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        chk("f_idle_after_clear", {63'd0, busy}, 64'd0);
        tracking = 0;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            abort = ($urandom_range(0, 49) == 0);
            done_ack = ($urandom_range(0, 2) == 0);
            if (!busy) begin
                op_m = 4'($urandom_range(0, 15));
                if (op_m == 4'b1000) op_m = 4'b0111;
                op_q = 4'($urandom_range(0, 15));
                start = ($urandom_range(0, 2) == 0);
            end else begin
                start = ($urandom_range(0, 3) == 0);
            end
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; done_ack = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
